ps2_scancode_receiver: RTL and testbench



---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_clk_filter.sv | 63 ++++++
 rtl/ps2_scancode_receiver.sv | 133 +++++++++++++
 tb/tb_ps2_scancode_receiver.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receiver constants, state encoding and parity helper
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX   = 8'hE0;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - pin synchronizers, PS/2 clock deglitch and falling-edge sample strobe
module ps2_clk_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic filt_clk,
    output logic sync_data,
    output logic sample
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic [CW-1:0]          stable_cnt;
    logic                   filt_d;
    logic                   clk_s;

    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign sync_data = data_sync[SYNC_STAGES-1];

    // Multi-flop synchronizers; both pins idle high so the chains reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Filtered clock follows the synchronized clock only after FILTER_LEN differing samples in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_clk   <= 1'b1;
            stable_cnt <= '0;
        end else if (clk_s == filt_clk) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CW'(FILTER_LEN - 1)) begin
            filt_clk   <= clk_s;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

    // Registered one-cycle strobe on each 1->0 transition of the filtered clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_d <= 1'b1;
            sample <= 1'b0;
        end else begin
            filt_d <= filt_clk;
            sample <= filt_d & ~filt_clk;
        end
    end

endmodule

// File: rtl/ps2_scancode_receiver.sv
// rtl/ps2_scancode_receiver.sv - PS/2 frame deserializer with valid/ack scan-code handoff
module ps2_scancode_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iPs2Clk,
    input  logic       iPs2Data,
    input  logic       iAck,
    output logic [7:0] oScanCode,
    output logic       oValid,
    output logic       oParityErr,
    output logic       oFrameErr,
    output logic       oOverrun
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_t    state;
    ps2_state_t    state_nxt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tcnt;

    logic filt_clk;
    logic sync_data;
    logic sample;
    logic sample_ev;
    logic timeout;
    logic stop_seen;
    logic good;
    logic load;
    logic frame_err_nxt;
    logic parity_err_nxt;
    logic overrun_nxt;

    ps2_clk_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filter (
        .clk       (Clock),
        .rst       (Reset),
        .ps2_clk   (iPs2Clk),
        .ps2_data  (iPs2Data),
        .filt_clk  (filt_clk),
        .sync_data (sync_data),
        .sample    (sample)
    );

    // The strobe only ever fires while the filtered clock is low.
    assign sample_ev = sample & ~filt_clk;

    // Abort lands TIMEOUT_CYCLES edges after the edge that consumed the last sample; a sample wins.
    assign timeout = (state != IDLE) && !sample_ev && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: frame progress on sample events, timeout back to IDLE.
    always_comb begin
        state_nxt = state;
        if (sample_ev) begin
            case (state)
                IDLE:    if (!sync_data) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'(DATA_BITS - 1)) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                default: state_nxt = IDLE;
            endcase
        end else if (timeout) begin
            state_nxt = IDLE;
        end
    end

    // Output decisions at the stop bit: framing first, then parity, then delivery or overrun.
    always_comb begin
        stop_seen      = sample_ev && (state == STOP);
        frame_err_nxt  = (stop_seen && !sync_data) || timeout;
        parity_err_nxt = stop_seen && sync_data && !odd_parity_ok(shift, par_bit);
        good           = stop_seen && sync_data && odd_parity_ok(shift, par_bit);
        load           = good && (!oValid || iAck);
        overrun_nxt    = good && oValid && !iAck;
    end

    // Datapath: shift register, counters, held scan code and one-cycle status pulses.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            tcnt       <= '0;
            oScanCode  <= '0;
            oValid     <= 1'b0;
            oParityErr <= 1'b0;
            oFrameErr  <= 1'b0;
            oOverrun   <= 1'b0;
        end else begin
            oFrameErr  <= frame_err_nxt;
            oParityErr <= parity_err_nxt;
            oOverrun   <= overrun_nxt;

            if (sample_ev || state == IDLE) tcnt <= '0;
            else                            tcnt <= tcnt + 1'b1;

            if (sample_ev) begin
                case (state)
                    IDLE: bit_cnt <= '0;
                    DATA: begin
                        shift   <= {sync_data, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY:  par_bit <= sync_data;
                    default: ;
                endcase
            end

            if (load) begin
                oScanCode <= shift;
                oValid    <= 1'b1;
            end else if (iAck) begin
                oValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// tb/tb_ps2_scancode_receiver.sv - self-checking bench for ps2_scancode_receiver
module tb_ps2_scancode_receiver;
    import ps2_pkg::*;

    localparam int S    = 2;
    localparam int F    = 8;
    localparam int T    = 300;
    localparam int HALF = 20;
    localparam int LAT  = S + F + 1;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       iPs2Clk = 1'b1;
    logic       iPs2Data = 1'b1;
    logic       iAck = 1'b0;
    logic [7:0] oScanCode;
    logic       oValid, oParityErr, oFrameErr, oOverrun;

    int checks = 0;
    int errors = 0;
    int n_perr = 0, n_ferr = 0, n_ovr = 0;

    logic       m_valid = 1'b0;
    logic [7:0] m_code  = 8'h00;

    ps2_scancode_receiver #(
        .SYNC_STAGES    (S),
        .FILTER_LEN     (F),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .iPs2Clk    (iPs2Clk),
        .iPs2Data   (iPs2Data),
        .iAck       (iAck),
        .oScanCode  (oScanCode),
        .oValid     (oValid),
        .oParityErr (oParityErr),
        .oFrameErr  (oFrameErr),
        .oOverrun   (oOverrun)
    );

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (oParityErr === 1'b1) n_perr++;
        if (oFrameErr === 1'b1)  n_ferr++;
        if (oOverrun === 1'b1)   n_ovr++;
    end

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic p;
        p = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        if (bad_par) p = ~p;
        return {~bad_stop, p, d, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        @(negedge Clock) iPs2Data = b;
        repeat (HALF) @(negedge Clock);
        iPs2Clk = 1'b0;
        repeat (HALF) @(negedge Clock);
        iPs2Clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
    endtask

    task automatic fall_and_sync(input logic b);
        @(negedge Clock) iPs2Data = b;
        repeat (HALF) @(negedge Clock);
        iPs2Clk = 1'b0;
        @(posedge Clock);
        #1;
    endtask

    task automatic settle();
        @(negedge Clock) iPs2Data = 1'b1;
        repeat (2 * HALF) @(negedge Clock);
    endtask

    task automatic ack_pulse();
        @(negedge Clock) iAck = 1'b1;
        @(negedge Clock) iAck = 1'b0;
    endtask

    task automatic test_reset();
        #1 Reset = 1'b1;
        repeat (3) @(negedge Clock);
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", oValid); end
        checks++; if (oScanCode !== 8'h00) begin errors++; $display("FAIL reset_code got %h want 00", oScanCode); end
        checks++; if ({oParityErr, oFrameErr, oOverrun} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {oParityErr, oFrameErr, oOverrun}); end
        Reset = 1'b0;
        repeat (5) @(negedge Clock);
    endtask

    task automatic test_good_frame();
        int lat;
        send_bits(mk_frame(8'h1C, 0, 0), FRAME_BITS - 1);
        fall_and_sync(1'b1);
        lat = 0;
        while (oValid !== 1'b1 && lat < 200) begin
            @(posedge Clock); #1; lat++;
            if (lat == HALF) iPs2Clk = 1'b1;
        end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL good_latency got %0d want %0d", lat, LAT); end
        checks++; if (oScanCode !== 8'h1C) begin errors++; $display("FAIL good_code got %h want 1c", oScanCode); end
        @(negedge Clock) iPs2Clk = 1'b1;
        repeat (30) @(negedge Clock);
        checks++; if (oValid !== 1'b1) begin errors++; $display("FAIL good_held got %b want 1", oValid); end
        ack_pulse();
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL good_ack_clear got %b want 0", oValid); end
        m_valid = 1'b0; m_code = 8'h1C;
    endtask

    task automatic test_bad_parity();
        int p0, f0;
        p0 = n_perr; f0 = n_ferr;
        send_bits(mk_frame(8'h1C, 1, 0), FRAME_BITS);
        settle();
        checks++; if (n_perr - p0 !== 1) begin errors++; $display("FAIL parity_pulse got %0d want 1", n_perr - p0); end
        checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL parity_no_frame got %0d want 0", n_ferr - f0); end
        checks++; if (oValid !== 1'b0 || oScanCode !== 8'h1C) begin errors++; $display("FAIL parity_out got %b/%h want 0/1c", oValid, oScanCode); end
    endtask

    task automatic test_bad_stop();
        int p0, f0;
        p0 = n_perr; f0 = n_ferr;
        send_bits(mk_frame(8'h5A, 0, 1), FRAME_BITS);
        settle();
        checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL stop_pulse got %0d want 1", n_ferr - f0); end
        checks++; if (n_perr - p0 !== 0) begin errors++; $display("FAIL stop_no_parity got %0d want 0", n_perr - p0); end
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL stop_valid got %b want 0", oValid); end
    endtask

    task automatic test_overrun();
        int o0;
        send_bits(mk_frame(BREAK_PREFIX, 0, 0), FRAME_BITS);
        settle();
        checks++; if (oValid !== 1'b1 || oScanCode !== 8'hF0) begin errors++; $display("FAIL ovr_first got %b/%h want 1/f0", oValid, oScanCode); end
        o0 = n_ovr;
        send_bits(mk_frame(8'h1C, 0, 0), FRAME_BITS);
        settle();
        checks++; if (n_ovr - o0 !== 1) begin errors++; $display("FAIL ovr_pulse got %0d want 1", n_ovr - o0); end
        checks++; if (oValid !== 1'b1 || oScanCode !== 8'hF0) begin errors++; $display("FAIL ovr_hold got %b/%h want 1/f0", oValid, oScanCode); end
        o0 = n_ovr;
        send_bits(mk_frame(8'h5A, 0, 0), FRAME_BITS - 1);
        fall_and_sync(1'b1);
        repeat (LAT - 1) @(posedge Clock);
        #1 iAck = 1'b1;
        @(posedge Clock);
        #1 iAck = 1'b0;
        repeat (HALF) @(negedge Clock);
        iPs2Clk = 1'b1;
        settle();
        checks++; if (oValid !== 1'b1 || oScanCode !== 8'h5A) begin errors++; $display("FAIL b2b_ack got %b/%h want 1/5a", oValid, oScanCode); end
        checks++; if (n_ovr - o0 !== 0) begin errors++; $display("FAIL b2b_no_overrun got %0d want 0", n_ovr - o0); end
        ack_pulse();
        m_valid = 1'b0; m_code = 8'h5A;
    endtask

    task automatic test_glitch_timeout();
        int p0, f0, o0, cnt;
        logic [10:0] fr;
        p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
        @(negedge Clock) begin iPs2Data = 1'b0; iPs2Clk = 1'b0; end
        repeat (F - 1) @(negedge Clock);
        iPs2Clk = 1'b1;
        repeat (4) @(negedge Clock);
        iPs2Data = 1'b1;
        repeat (20) @(negedge Clock);
        checks++; if ((n_perr - p0) + (n_ferr - f0) + (n_ovr - o0) !== 0 || oValid !== 1'b0) begin errors++; $display("FAIL glitch_quiet got pulses %0d valid %b want 0/0", (n_perr - p0) + (n_ferr - f0) + (n_ovr - o0), oValid); end
        fr = mk_frame(8'h33, 0, 0);
        send_bits(fr, 4);
        fall_and_sync(fr[4]);
        cnt = 0;
        while (oFrameErr !== 1'b1 && cnt < LAT + T + 50) begin
            @(posedge Clock); #1; cnt++;
            if (cnt == HALF) iPs2Clk = 1'b1;
        end
        checks++; if (cnt !== LAT + T) begin errors++; $display("FAIL timeout_latency got %0d want %0d", cnt, LAT + T); end
        settle();
        send_bits(mk_frame(8'h5A, 0, 0), FRAME_BITS);
        settle();
        checks++; if (oValid !== 1'b1 || oScanCode !== 8'h5A) begin errors++; $display("FAIL after_timeout got %b/%h want 1/5a", oValid, oScanCode); end
        m_valid = 1'b1; m_code = 8'h5A;
    endtask

    task automatic test_reset_midframe();
        send_bits(mk_frame(8'h1C, 0, 0), 5);
        @(negedge Clock);
        #2 Reset = 1'b1;
        #1;
        checks++; if ({oValid, oScanCode, oParityErr, oFrameErr, oOverrun} !== 12'h000) begin errors++; $display("FAIL async_reset got %b/%h want 0/00", oValid, oScanCode); end
        @(negedge Clock) begin Reset = 1'b0; iPs2Data = 1'b1; end
        settle();
        send_bits(mk_frame(8'h1C, 0, 0), FRAME_BITS);
        settle();
        checks++; if (oValid !== 1'b1 || oScanCode !== 8'h1C) begin errors++; $display("FAIL post_reset got %b/%h want 1/1c", oValid, oScanCode); end
        ack_pulse();
        m_valid = 1'b0; m_code = 8'h1C;
    endtask

    task automatic test_random();
        int p0, f0, o0, ep, ef, eo, r;
        logic [7:0] d;
        bit bp, bs;
        for (int k = 0; k < 24; k++) begin
            d  = ($urandom_range(0, 3) == 0) ? EXT_PREFIX : 8'($urandom);
            r  = $urandom_range(0, 5);
            bp = (r == 0);
            bs = (r == 1);
            ep = 0; ef = 0; eo = 0;
            if (bs) ef = 1;
            else if (bp) ep = 1;
            else if (m_valid) eo = 1;
            else begin m_valid = 1'b1; m_code = d; end
            p0 = n_perr; f0 = n_ferr; o0 = n_ovr;
            send_bits(mk_frame(d, bp, bs), FRAME_BITS);
            settle();
            checks++; if (n_perr - p0 !== ep || n_ferr - f0 !== ef || n_ovr - o0 !== eo) begin errors++; $display("FAIL rand_pulses[%0d] got p%0d f%0d o%0d want p%0d f%0d o%0d", k, n_perr - p0, n_ferr - f0, n_ovr - o0, ep, ef, eo); end
            checks++; if (oValid !== m_valid || oScanCode !== m_code) begin errors++; $display("FAIL rand_out[%0d] got %b/%h want %b/%h", k, oValid, oScanCode, m_valid, m_code); end
            if ($urandom_range(0, 1) == 1) begin
                ack_pulse();
                m_valid = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_parity();
        test_bad_stop();
        test_overrun();
        test_glitch_timeout();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
